// File: rtl/demapper_llr.sv
`default_nettype none
// ============================================================================
//  Module      : demapper_llr
//  Description : Soft-decision demapper. Turns equalised {Q,I} symbols into
//                scaled, rounded and saturated LLR pairs, 1-3 beats per symbol.
//  Revision    : 1.0
// ============================================================================
module demapper_llr #(
    parameter int DATA_W      = 16,
    parameter int SCALE_W     = 16,
    parameter int SCALE_SHIFT = 12,
    parameter int OUT_W       = 16,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*DATA_W-1:0] t_data,
    input  logic                t_last,
    input  logic                t_valid,
    output logic                t_ready,
    output logic [2*OUT_W-1:0]  i_data,
    output logic [1:0]          i_beat,
    output logic                i_last,
    output logic                i_valid,
    input  logic                i_ready,
    input  logic [2:0]          constellation,
    input  logic [SCALE_W-1:0]  two_over_sigma_sq,
    output logic                err_bad_mode,
    output logic [CNT_W-1:0]    sym_count,
    output logic                busy
);

    localparam int c_BW = DATA_W + 2;
    localparam int c_PW = DATA_W + 2 + SCALE_W + 1;

    localparam logic [2:0] c_QPSK  = 3'd0;
    localparam logic [2:0] c_8PSK  = 3'd1;
    localparam logic [2:0] c_QAM16 = 3'd2;
    localparam logic [2:0] c_QAM64 = 3'd3;
    localparam logic [2:0] c_BPSK  = 3'd4;

    localparam logic signed [c_BW-1:0] c_A    = c_BW'(1) << (DATA_W - 3);
    localparam logic signed [c_BW-1:0] c_B    = c_BW'(1) << (DATA_W - 2);
    // (1 << SHIFT) >> 1 yields zero rounding offset when SCALE_SHIFT is 0
    localparam logic signed [c_PW:0]   c_RND  = ((c_PW+1)'(1) << SCALE_SHIFT) >> 1;
    localparam logic signed [c_PW:0]   c_SMAX = ((c_PW+1)'(1) << (OUT_W - 1)) - (c_PW+1)'(1);
    localparam logic signed [c_PW:0]   c_SMIN = -c_SMAX;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DROP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_mode;
    logic [1:0]             r_beat;
    logic                   r_first;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;

    logic                   r_s1_valid;
    logic signed [c_PW-1:0] r_s1_re;
    logic signed [c_PW-1:0] r_s1_im;
    logic [1:0]             r_s1_beat;
    logic                   r_s1_last;

    logic                   r_s2_valid;
    logic [2*OUT_W-1:0]     r_s2_data;
    logic [1:0]             r_s2_beat;
    logic                   r_s2_last;

    logic                   w_mode_ok;
    logic [1:0]             w_last_idx;
    logic                   w_issue;
    logic                   w_sym_done;
    logic                   w_s1_ok;
    logic                   w_s2_ok;

    logic signed [c_BW-1:0] w_i;
    logic signed [c_BW-1:0] w_q;
    logic signed [c_BW-1:0] w_ai;
    logic signed [c_BW-1:0] w_aq;
    logic signed [c_BW-1:0] w_di;
    logic signed [c_BW-1:0] w_dq;
    logic signed [c_BW-1:0] w_adi;
    logic signed [c_BW-1:0] w_adq;
    logic signed [c_BW-1:0] w_re;
    logic signed [c_BW-1:0] w_im;
    logic signed [c_PW-1:0] w_scale;
    logic signed [c_PW-1:0] w_p_re;
    logic signed [c_PW-1:0] w_p_im;

    function automatic logic [OUT_W-1:0] f_round_sat(input logic signed [c_PW-1:0] p);
        logic signed [c_PW:0] v;
        v = ((c_PW+1)'(p) + c_RND) >>> SCALE_SHIFT;
        if (v > c_SMAX)
            f_round_sat = c_SMAX[OUT_W-1:0];
        else if (v < c_SMIN)
            f_round_sat = c_SMIN[OUT_W-1:0];
        else
            f_round_sat = v[OUT_W-1:0];
    endfunction

    assign w_mode_ok  = (constellation <= c_BPSK);
    assign w_s2_ok    = !r_s2_valid || i_ready;
    assign w_s1_ok    = !r_s1_valid || w_s2_ok;
    assign w_sym_done = w_issue && (r_beat == w_last_idx);

    always_comb begin
        w_last_idx = 2'd0;
        case (r_mode)
            c_8PSK, c_QAM16: w_last_idx = 2'd1;
            c_QAM64:         w_last_idx = 2'd2;
            default:         w_last_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        t_ready     = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (t_valid)
                    w_state_nxt = w_mode_ok ? S_ACTIVE : S_DROP;
            end
            S_ACTIVE: begin
                // symbol is held upstream until its final beat is issued
                w_issue = t_valid && w_s1_ok;
                t_ready = w_s1_ok && (r_beat == w_last_idx);
                if (w_issue && t_ready && t_last)
                    w_state_nxt = S_IDLE;
            end
            S_DROP: begin
                t_ready = 1'b1;
                if (t_valid && t_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= c_QPSK;
            r_beat  <= 2'd0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && t_valid) begin
                r_mode  <= constellation;
                r_first <= 1'b1;
                r_beat  <= 2'd0;
                if (!w_mode_ok)
                    r_err <= 1'b1;
            end
            if (w_issue) begin
                if (w_sym_done) begin
                    r_beat  <= 2'd0;
                    r_first <= 1'b0;
                    r_cnt   <= r_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
                end else begin
                    r_beat <= r_beat + 2'd1;
                end
            end
        end
    end

    assign w_i   = c_BW'($signed(t_data[DATA_W-1:0]));
    assign w_q   = c_BW'($signed(t_data[2*DATA_W-1:DATA_W]));
    assign w_ai  = w_i[c_BW-1] ? -w_i : w_i;
    assign w_aq  = w_q[c_BW-1] ? -w_q : w_q;
    assign w_di  = w_ai - c_B;
    assign w_dq  = w_aq - c_B;
    assign w_adi = w_di[c_BW-1] ? -w_di : w_di;
    assign w_adq = w_dq[c_BW-1] ? -w_dq : w_dq;

    always_comb begin
        w_re = w_i;
        w_im = w_q;
        case (r_mode)
            c_BPSK: w_im = '0;
            c_8PSK: begin
                if (r_beat == 2'd1) begin
                    w_re = w_ai - w_aq;
                    w_im = '0;
                end
            end
            c_QAM16: begin
                if (r_beat == 2'd1) begin
                    w_re = w_ai - c_A;
                    w_im = w_aq - c_A;
                end
            end
            c_QAM64: begin
                if (r_beat == 2'd1) begin
                    w_re = c_B - w_ai;
                    w_im = c_B - w_aq;
                end else if (r_beat == 2'd2) begin
                    w_re = c_A - w_adi;
                    w_im = c_A - w_adq;
                end
            end
            default: ;
        endcase
    end

    assign w_scale = c_PW'($signed({1'b0, two_over_sigma_sq}));
    assign w_p_re  = c_PW'(w_re) * w_scale;
    assign w_p_im  = c_PW'(w_im) * w_scale;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_beat  <= 2'd0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_beat  <= 2'd0;
            r_s2_last  <= 1'b0;
        end else begin
            if (w_s1_ok) begin
                r_s1_valid <= w_issue;
                if (w_issue) begin
                    r_s1_re   <= w_p_re;
                    r_s1_im   <= w_p_im;
                    r_s1_beat <= r_beat;
                    r_s1_last <= t_last && w_sym_done;
                end
            end
            if (w_s2_ok) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= {f_round_sat(r_s1_im), f_round_sat(r_s1_re)};
                    r_s2_beat <= r_s1_beat;
                    r_s2_last <= r_s1_last;
                end
            end
        end
    end

    assign i_valid      = r_s2_valid;
    assign i_data       = r_s2_data;
    assign i_beat       = r_s2_beat;
    assign i_last       = r_s2_last;
    assign err_bad_mode = r_err;
    assign sym_count    = r_cnt;
    assign busy         = r_s1_valid || r_s2_valid || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_demapper_llr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demapper_llr
//  Description : Randomised and directed self-checking bench for demapper_llr.
//  Revision    : 1.0
// ============================================================================
module tb_demapper_llr;

    typedef struct packed {
        logic        l;
        logic [1:0]  b;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] t_data = '0;
    logic        t_last = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_ready;
    logic [31:0] i_data;
    logic [1:0]  i_beat;
    logic        i_last;
    logic        i_valid;
    logic        i_ready = 1'b0;
    logic [2:0]  constellation = 3'd0;
    logic [15:0] two_over_sigma_sq = 16'h1000;
    logic        err_bad_mode;
    logic [15:0] sym_count;
    logic        busy;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_xfer = 0;
    int   stall_pct = 0;
    exp_t exp_q[$];
    exp_t e_pop;
    bit   held = 1'b0;
    logic [35:0] held_v;

    demapper_llr dut (
        .clk               (clk),
        .rst               (rst),
        .t_data            (t_data),
        .t_last            (t_last),
        .t_valid           (t_valid),
        .t_ready           (t_ready),
        .i_data            (i_data),
        .i_beat            (i_beat),
        .i_last            (i_last),
        .i_valid           (i_valid),
        .i_ready           (i_ready),
        .constellation     (constellation),
        .two_over_sigma_sq (two_over_sigma_sq),
        .err_bad_mode      (err_bad_mode),
        .sym_count         (sym_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: soft values from plain integer arithmetic.
    function automatic longint iabs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [15:0] llr(input longint x, input longint s);
        longint y;
        y = (x * s + 2048) >>> 12;
        if (y > 32767)  y = 32767;
        if (y < -32767) y = -32767;
        return 16'(y);
    endfunction

    task automatic push_exp(input bit l, input int b, input logic [31:0] d);
        exp_t e;
        e.l = l;
        e.b = 2'(b);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_model(input int mode, input logic [31:0] d, input bit last, input int s);
        longint i, q, ai, aq;
        longint re[3];
        longint im[3];
        int     nb;
        longint A, B;
        A  = 8192;
        B  = 16384;
        i  = longint'($signed(d[15:0]));
        q  = longint'($signed(d[31:16]));
        ai = iabs(i);
        aq = iabs(q);
        re[0] = i; im[0] = q; re[1] = 0; im[1] = 0; re[2] = 0; im[2] = 0;
        nb = 1;
        case (mode)
            4: im[0] = 0;
            1: begin nb = 2; re[1] = ai - aq; im[1] = 0; end
            2: begin nb = 2; re[1] = ai - A;  im[1] = aq - A; end
            3: begin
                nb = 3;
                re[1] = B - ai;             im[1] = B - aq;
                re[2] = A - iabs(ai - B);   im[2] = A - iabs(aq - B);
            end
            default: ;
        endcase
        for (int b = 0; b < nb; b++)
            push_exp(last && (b == nb - 1), b, {llr(im[b], s), llr(re[b], s)});
    endtask

    // Output sink: random ready, hold-stability and scoreboard checks.
    always @(negedge clk) begin
        i_ready = ($urandom_range(0, 99) >= stall_pct);
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held)
                check_val("hold_stable", {i_valid, i_last, i_beat, i_data}, held_v);
            held = 1'b0;
            if (i_valid && i_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", {1'b1, i_last, i_beat, i_data}, 64'd0);
                end else begin
                    e_pop = exp_q.pop_front();
                    check_val("beat", {i_last, i_beat, i_data}, e_pop);
                end
            end else if (i_valid) begin
                held   = 1'b1;
                held_v = {i_valid, i_last, i_beat, i_data};
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 after the accepting edge.
    task automatic send_sym(input logic [31:0] d, input bit last, output int waits);
        bit ok;
        ok      = 1'b0;
        waits   = 0;
        t_data  = d;
        t_last  = last;
        t_valid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            #1;
            if (t_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
            #1;
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end else begin
            check_val("t_ready_timeout", 64'(ok), 64'd1);
        end
        t_valid = 1'b0;
        t_last  = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int n, input int sc);
        int          w;
        logic [31:0] d;
        constellation     = 3'(mode);
        two_over_sigma_sq = 16'(sc);
        for (int s = 0; s < n; s++) begin
            d = $urandom;
            if (mode <= 4)
                push_model(mode, d, s == n - 1, sc);
            send_sym(d, s == n - 1, w);
            constellation = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4000; k++) begin
            if (exp_q.size() == 0 && !busy)
                break;
            @(negedge clk);
            #1;
        end
        check_val("drain_left", 64'(exp_q.size()), 64'd0);
        check_val("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n0;
        int n;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_t_ready", 64'(t_ready), 64'd0);
        check_val("rst_i_valid", 64'(i_valid), 64'd0);
        check_val("rst_outputs", {i_last, i_beat, i_data}, 64'd0);
        check_val("rst_err", 64'(err_bad_mode), 64'd0);
        check_val("rst_sym_count", 64'(sym_count), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // QPSK single symbol: value and two-cycle latency
        stall_pct = 0;
        constellation = 3'd0;
        two_over_sigma_sq = 16'h1000;
        push_exp(1'b1, 0, 32'hF000_1000);
        send_sym(32'hF000_1000, 1'b1, w);
        check_val("latency_1", 64'(i_valid), 64'd0);
        @(negedge clk);
        #1;
        check_val("latency_2", 64'(i_valid), 64'd1);
        drain();
        check_val("qpsk_sym_count", 64'(sym_count), 64'd1);

        // QAM16 with most-negative Q
        constellation = 3'd2;
        push_exp(1'b0, 0, 32'h8001_3000);
        push_exp(1'b1, 1, 32'h6000_1000);
        send_sym(32'h8000_3000, 1'b1, w);
        drain();

        // QAM64 two-symbol frame; mid-frame symbol waits for its third beat
        constellation = 3'd3;
        push_exp(1'b0, 0, 32'h5000_5000);
        push_exp(1'b0, 1, 32'hF000_F000);
        push_exp(1'b0, 2, 32'h1000_1000);
        push_exp(1'b0, 0, 32'h5000_5000);
        push_exp(1'b0, 1, 32'hF000_F000);
        push_exp(1'b1, 2, 32'h1000_1000);
        send_sym(32'h5000_5000, 1'b0, w);
        send_sym(32'h5000_5000, 1'b1, w);
        check_val("qam64_wait_beats", 64'(w), 64'd2);
        drain();
        check_val("qam64_sym_count", 64'(sym_count), 64'd2);

        // BPSK saturation and rounding boundaries
        constellation = 3'd4;
        two_over_sigma_sq = 16'hFFFF;
        push_exp(1'b1, 0, 32'h0000_7FFF);
        send_sym(32'h0000_7FFF, 1'b1, w);
        two_over_sigma_sq = 16'h0800;
        push_exp(1'b1, 0, 32'h0000_0001);
        send_sym(32'h0000_0001, 1'b1, w);
        push_exp(1'b1, 0, 32'h0000_0000);
        send_sym(32'h0000_FFFF, 1'b1, w);
        drain();

        // 100-symbol 8PSK frame under 30% backpressure
        stall_pct = 30;
        n0 = n_xfer;
        send_frame(1, 100, $urandom_range(1, 65535));
        drain();
        check_val("8psk_beats", 64'(n_xfer - n0), 64'd200);
        check_val("8psk_sym_count", 64'(sym_count), 64'd100);

        // Invalid mode frame is swallowed, then normal traffic resumes
        n0 = n_xfer;
        send_frame(5, 4, 16'h1000);
        drain();
        check_val("drop_no_output", 64'(n_xfer - n0), 64'd0);
        check_val("drop_err", 64'(err_bad_mode), 64'd1);
        send_frame(0, 5, $urandom_range(0, 65535));
        drain();
        check_val("after_drop_sym_count", 64'(sym_count), 64'd5);

        // Random frames over every valid mode
        for (int m = 0; m < 5; m++) begin
            n = $urandom_range(3, 12);
            send_frame(m, n, $urandom_range(0, 65535));
            drain();
            check_val("rand_sym_count", 64'(sym_count), 64'(n));
        end
        check_val("err_sticky", 64'(err_bad_mode), 64'd1);

        // Reset in the middle of a stalled QAM64 frame
        stall_pct = 100;
        constellation = 3'd3;
        two_over_sigma_sq = 16'h1000;
        t_data = 32'h1234_4321;
        t_last = 1'b0;
        t_valid = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_val("pre_rst_busy", 64'(busy), 64'd1);
        check_val("pre_rst_valid", 64'(i_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_t_ready", 64'(t_ready), 64'd0);
        check_val("mid_rst_i_valid", 64'(i_valid), 64'd0);
        check_val("mid_rst_outputs", {i_last, i_beat, i_data}, 64'd0);
        check_val("mid_rst_err", 64'(err_bad_mode), 64'd0);
        check_val("mid_rst_sym_count", 64'(sym_count), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        t_valid = 1'b0;
        @(negedge clk);
        #3;
        rst = 1'b0;
        stall_pct = 0;
        @(negedge clk);
        #1;
        send_frame(2, 4, $urandom_range(0, 65535));
        drain();
        check_val("post_rst_sym_count", 64'(sym_count), 64'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
